pc_branch_unit: RTL and testbench

Sequential next-PC and branch-resolution block for the single-cycle RV-32I core. It sits on the result side of the ALU. For a compare branch the ALU runs `SUB` on rs1/rs2, and this block takes the ALU flags (`zero`, `sgn`) plus the operand sign bits to decide taken / not-taken. It owns the PC register, selects PC+4, PC+imm or the JALR target, and flags misaligned targets with a sticky trap. It also keeps saturating branch statistics counters for the debug/trace bus.

---
 rtl/pc_branch_unit_if.sv | 31 +++
 rtl/pc_branch_unit.sv | 131 +++++++++++++
 tb/tb_pc_branch_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pc_branch_unit_if.sv
// Bus between the decode/ALU side and the next-PC / branch-resolution block.
// The decode side (master) drives branch type, immediate and ALU results;
// the branch unit (slave) returns the PC, redirect decision, status and statistics.
interface pc_branch_unit_if;
    logic        stall;
    logic [2:0]  br_type;
    logic [31:0] imm;
    logic [31:0] alu_c;
    logic        zero;
    logic        sgn;
    logic        a_msb;
    logic        b_msb;

    logic [31:0] pc;
    logic [31:0] pc4;
    logic        taken;
    logic        fetch_valid;
    logic        trap;
    logic [31:0] br_cnt;
    logic [31:0] taken_cnt;

    modport master (
        output stall, br_type, imm, alu_c, zero, sgn, a_msb, b_msb,
        input  pc, pc4, taken, fetch_valid, trap, br_cnt, taken_cnt
    );

    modport slave (
        input  stall, br_type, imm, alu_c, zero, sgn, a_msb, b_msb,
        output pc, pc4, taken, fetch_valid, trap, br_cnt, taken_cnt
    );
endinterface

// File: rtl/pc_branch_unit.sv
// Next-PC and branch-resolution block for the single-cycle RV-32I core.
// Resolves compare branches from ALU flags, owns the PC register, raises a
// sticky trap on misaligned targets and keeps saturating branch statistics.
module pc_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_branch_unit_if.slave  bus
);

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_JAL  = 3'd5;
    localparam logic [2:0] BR_JALR = 3'd6;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] br_cnt_q;
    logic [31:0] taken_cnt_q;

    logic        lt;
    logic        is_cmp;
    logic        taken;
    logic [31:0] pc4;
    logic [31:0] target;
    logic        misalign;
    logic        advance;
    logic        fetch_valid;
    logic        trap;

    // Decode the branch type into a taken decision; lt picks the operand sign when signs differ so SUB overflow cannot flip it
    always_comb begin
        lt     = (bus.a_msb != bus.b_msb) ? bus.a_msb : bus.sgn;
        taken  = 1'b0;
        is_cmp = 1'b0;
        case (bus.br_type)
            BR_BEQ:  begin is_cmp = 1'b1; taken = bus.zero;  end
            BR_BNE:  begin is_cmp = 1'b1; taken = ~bus.zero; end
            BR_BLT:  begin is_cmp = 1'b1; taken = lt;        end
            BR_BGE:  begin is_cmp = 1'b1; taken = ~lt;       end
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            BR_NONE: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

    // Select the next PC and detect a taken target that is not word aligned
    always_comb begin
        pc4 = pc_q + 32'd4;
        if (!taken) begin
            target = pc4;
        end else if (bus.br_type == BR_JALR) begin
            target = bus.alu_c & ~32'h1;
        end else begin
            target = pc_q + bus.imm;
        end
        misalign = taken & (target[1:0] != 2'b00);
        advance  = (state_q == ST_RUN) && !bus.stall;
    end

    // State register: RESET on reset, then RUN, TRAP is terminal until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a stalled edge holds the state like every other register
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: if (!bus.stall) state_d = ST_RUN;
            ST_RUN:   if (!bus.stall && misalign) state_d = ST_TRAP;
            ST_TRAP:  state_d = ST_TRAP;
            default:  state_d = ST_RESET;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        fetch_valid = (state_q == ST_RUN);
        trap        = (state_q == ST_TRAP);
    end

    // PC register: advances only while running unstalled and the target is aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (advance && !misalign) begin
            pc_q <= target;
        end
    end

    // Saturating statistics for compare branches, including the one that traps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= 32'd0;
            taken_cnt_q <= 32'd0;
        end else if (advance && is_cmp) begin
            if (br_cnt_q != 32'hFFFF_FFFF) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (taken && (taken_cnt_q != 32'hFFFF_FFFF)) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc4         = pc4;
    assign bus.taken       = taken;
    assign bus.fetch_valid = fetch_valid;
    assign bus.trap        = trap;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: a table of per-cycle vectors with
// hand-computed results, plus sequences for async reset, stall and wrap.
module tb_pc_branch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        logic        stall;
        logic [2:0]  br_type;
        logic [31:0] imm;
        logic [31:0] alu_c;
        logic        zero;
        logic        sgn;
        logic        a_msb;
        logic        b_msb;
        logic        exp_taken;
        logic [31:0] exp_pc;
        logic [31:0] exp_br;
        logic [31:0] exp_tk;
        logic        exp_trap;
        logic        exp_fv;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_branch_unit_if bus ();

    pc_branch_unit #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic st, input logic [2:0] bt, input logic [31:0] im,
                                   input logic [31:0] ac, input logic z, input logic s,
                                   input logic a, input logic b, input logic et,
                                   input logic [31:0] epc, input logic [31:0] ebr,
                                   input logic [31:0] etk, input logic etr, input logic efv);
        vec_t v;
        v.stall = st; v.br_type = bt; v.imm = im; v.alu_c = ac;
        v.zero = z; v.sgn = s; v.a_msb = a; v.b_msb = b;
        v.exp_taken = et; v.exp_pc = epc; v.exp_br = ebr; v.exp_tk = etk;
        v.exp_trap = etr; v.exp_fv = efv;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input vec_t v);
        bus.stall   = v.stall;
        bus.br_type = v.br_type;
        bus.imm     = v.imm;
        bus.alu_c   = v.alu_c;
        bus.zero    = v.zero;
        bus.sgn     = v.sgn;
        bus.a_msb   = v.a_msb;
        bus.b_msb   = v.b_msb;
    endtask

    // Called on a falling edge: drive, check taken, clock once, check registered state
    task automatic applyStimulus(input vec_t v, input string tag);
        driveInputs(v);
        #1;
        checkOutput({tag, ".taken"}, {31'd0, bus.taken}, {31'd0, v.exp_taken});
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, ".pc"},          bus.pc,              v.exp_pc);
        checkOutput({tag, ".pc4"},         bus.pc4,             v.exp_pc + 32'd4);
        checkOutput({tag, ".br_cnt"},      bus.br_cnt,          v.exp_br);
        checkOutput({tag, ".taken_cnt"},   bus.taken_cnt,       v.exp_tk);
        checkOutput({tag, ".trap"},        {31'd0, bus.trap},        {31'd0, v.exp_trap});
        checkOutput({tag, ".fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, v.exp_fv});
    endtask

    vec_t vecs[18];
    vec_t hv;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        driveInputs(mkVec(0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));

        //           st br   imm           alu_c         z  s  a  b  tk  pc            br tk trap fv
        vecs[0]  = mkVec(0, 3'd0, 32'h0000_0000, 32'h0, 0, 0, 0, 0, 0, 32'h0000_0100, 0, 0, 0, 1);
        vecs[1]  = mkVec(0, 3'd0, 32'h0000_0000, 32'h0, 0, 0, 0, 0, 0, 32'h0000_0104, 0, 0, 0, 1);
        vecs[2]  = mkVec(0, 3'd0, 32'h0000_0000, 32'h0, 0, 0, 0, 0, 0, 32'h0000_0108, 0, 0, 0, 1);
        vecs[3]  = mkVec(0, 3'd3, 32'h0000_0020, 32'h0, 0, 1, 0, 1, 0, 32'h0000_010C, 1, 0, 0, 1);
        vecs[4]  = mkVec(0, 3'd5, 32'hFFFF_FF34, 32'h0, 0, 0, 0, 0, 1, 32'h0000_0040, 1, 0, 0, 1);
        vecs[5]  = mkVec(0, 3'd1, 32'hFFFF_FFF8, 32'h0, 1, 0, 0, 0, 1, 32'h0000_0038, 2, 1, 0, 1);
        vecs[6]  = mkVec(0, 3'd2, 32'h0000_0010, 32'h0, 0, 0, 0, 0, 1, 32'h0000_0048, 3, 2, 0, 1);
        vecs[7]  = mkVec(0, 3'd4, 32'h0000_0100, 32'h0, 0, 0, 1, 0, 0, 32'h0000_004C, 4, 2, 0, 1);
        vecs[8]  = mkVec(0, 3'd4, 32'h0000_0014, 32'h0, 0, 0, 0, 0, 1, 32'h0000_0060, 5, 3, 0, 1);
        vecs[9]  = mkVec(0, 3'd3, 32'h0000_0008, 32'h0, 0, 1, 1, 1, 1, 32'h0000_0068, 6, 4, 0, 1);
        vecs[10] = mkVec(0, 3'd1, 32'h0000_0040, 32'h0, 0, 0, 0, 0, 0, 32'h0000_006C, 7, 4, 0, 1);
        vecs[11] = mkVec(0, 3'd7, 32'h0000_0040, 32'h0, 1, 1, 0, 0, 0, 32'h0000_0070, 7, 4, 0, 1);
        vecs[12] = mkVec(1, 3'd1, 32'h0000_0010, 32'h0, 1, 0, 0, 0, 1, 32'h0000_0070, 7, 4, 0, 1);
        vecs[13] = mkVec(0, 3'd6, 32'h0000_0000, 32'h0000_0201, 0, 0, 0, 0, 1, 32'h0000_0200, 7, 4, 0, 1);
        vecs[14] = mkVec(1, 3'd6, 32'h0000_0000, 32'h0000_0202, 0, 0, 0, 0, 1, 32'h0000_0200, 7, 4, 0, 1);
        vecs[15] = mkVec(0, 3'd1, 32'h0000_0006, 32'h0, 1, 0, 0, 0, 1, 32'h0000_0200, 8, 5, 1, 0);
        vecs[16] = mkVec(0, 3'd2, 32'h0000_0010, 32'h0, 0, 0, 0, 0, 1, 32'h0000_0200, 8, 5, 1, 0);
        vecs[17] = mkVec(0, 3'd6, 32'h0000_0000, 32'h0000_0300, 0, 0, 0, 0, 1, 32'h0000_0200, 8, 5, 1, 0);

        // Reset values while rst_n is held low
        repeat (2) @(negedge clk);
        checkOutput("rst.pc",          bus.pc,                   RST_PC);
        checkOutput("rst.pc4",         bus.pc4,                  RST_PC + 32'd4);
        checkOutput("rst.fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
        checkOutput("rst.trap",        {31'd0, bus.trap},        32'd0);
        checkOutput("rst.br_cnt",      bus.br_cnt,               32'd0);
        checkOutput("rst.taken_cnt",   bus.taken_cnt,            32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset out of TRAP, checked before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset.pc",          bus.pc,                   RST_PC);
        checkOutput("areset.trap",        {31'd0, bus.trap},        32'd0);
        checkOutput("areset.fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
        checkOutput("areset.br_cnt",      bus.br_cnt,               32'd0);
        checkOutput("areset.taken_cnt",   bus.taken_cnt,            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkVec(0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, RST_PC, 0, 0, 0, 1), "rel");

        // Jump to the top of the address space, stall there, then wrap to zero
        applyStimulus(mkVec(0, 3'd5, 32'hFFFF_FEFC, 32'h0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1), "jtop");
        for (int i = 0; i < 3; i++) begin
            hv = mkVec(1, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 1);
            applyStimulus(hv, $sformatf("stall%0d", i));
        end
        applyStimulus(mkVec(0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1), "wrap");
        applyStimulus(mkVec(0, 3'd5, 32'hFFFF_FFF0, 32'h0, 0, 0, 0, 0, 1, 32'hFFFF_FFF0, 0, 0, 0, 1), "jneg");

        // pc+imm overflow wraps, then three taken compare branches in a row
        applyStimulus(mkVec(0, 3'd2, 32'h0000_0020, 32'h0, 0, 0, 0, 0, 1, 32'h0000_0010, 1, 1, 0, 1), "ovf");
        applyStimulus(mkVec(0, 3'd3, 32'h0000_0004, 32'h0, 0, 1, 0, 0, 1, 32'h0000_0014, 2, 2, 0, 1), "blt");
        applyStimulus(mkVec(0, 3'd4, 32'h0000_0008, 32'h0, 0, 0, 1, 1, 1, 32'h0000_001C, 3, 3, 0, 1), "bge");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
